// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes from the control decoder, FSM encoding and default width.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  typedef enum logic [3:0] {
    OP_NOP = 4'b0000,
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_MUL = 4'b0011,
    OP_AND = 4'b0100,
    OP_OR  = 4'b0101,
    OP_SRL = 4'b0110,
    OP_SLL = 4'b0111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, low WIDTH bits of a*b.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_c,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  logic             running;
  logic [WIDTH-1:0] pp_c;

  assign pp_c = mplier[0] ? mcand : '0;

  // count holds iterations completed; the final one is in flight when it reaches WIDTH-1
  assign done_c = running && (count == CW'(WIDTH - 1));

  // The start cycle folds iteration 0 into the load from a cleared accumulator
  always_ff @(posedge clk) begin
    if (reset) begin
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      product <= b[0] ? a : '0;
      mcand   <= a << 1;
      mplier  <= b >> 1;
      count   <= CW'(1);
      running <= 1'b1;
    end else if (running) begin
      product <= product + pp_c;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      count   <= count + CW'(1);
      if (done_c) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops registered in one clock, MUL via the iterative multiplier with busy stall.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  alu_state_e       state;
  logic [WIDTH-1:0] alu_c;
  logic             mul_start_c;
  logic             mul_done_c;
  logic [WIDTH-1:0] mul_product;

  // Single-cycle datapath; NOP, MUL and undefined codes yield zero here
  always_comb begin
    alu_c = '0;
    case (operation)
      OP_ADD:  alu_c = a + b;
      OP_SUB:  alu_c = a - b;
      OP_AND:  alu_c = a & b;
      OP_OR:   alu_c = a | b;
      OP_SRL:  alu_c = b >> shamt;
      OP_SLL:  alu_c = b << shamt;
      default: alu_c = '0;
    endcase
  end

  assign mul_start_c = (state == ST_IDLE) && in_valid && (operation == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start_c),
    .a       (a),
    .b       (b),
    .done_c  (mul_done_c),
    .product (mul_product)
  );

  // Control FSM and output registers; in_valid is only looked at in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (operation == OP_MUL) begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end else begin
              result    <= alu_c;
              zero      <= (alu_c == '0);
              out_valid <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (mul_done_c) state <= ST_DONE;
        end
        ST_DONE: begin
          result    <= mul_product;
          zero      <= (mul_product == '0);
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  operation;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic [7:0]  tag;
  } exp_t;

  exp_t exp_q[$];

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .operation (operation),
    .a         (a),
    .b         (b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [31:0] r, input logic [7:0] t);
    exp_t e;
    e.res = r;
    e.z   = (r == 32'd0);
    e.tag = t;
    exp_q.push_back(e);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [4:0] sh);
    in_valid  = 1'b1;
    operation = op;
    a         = aa;
    b         = bb;
    shamt     = sh;
  endtask

  // Monitor: every out_valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out_valid: got result=%h zero=%b required no pulse", result, zero);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (result !== e.res || zero !== e.z) begin
          failures++;
          $display("FAIL result_tag%0d: got result=%h zero=%b required result=%h zero=%b",
                   e.tag, result, zero, e.res, e.z);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; operation = 4'd0; a = '0; b = '0; shamt = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_zero", 32'(zero), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // ADD overflow wraps, one-cycle latency, single pulse
    set_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0); push(32'h8000_0000, 8'd1);
    @(negedge clk); in_valid = 1'b0;
    check("add_latency", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("add_single_pulse", 32'(out_valid), 32'd0);

    set_op(OP_SUB, 32'd5, 32'd5, 5'd0); push(32'd0, 8'd2);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);

    // Streaming: four ops, one per cycle
    set_op(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0); push(32'hF000_F000, 8'd3);
    @(negedge clk); check("stream_pulse1", 32'(out_valid), 32'd1);
    set_op(OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0); push(32'hFFF0_FFF0, 8'd4);
    @(negedge clk); check("stream_pulse2", 32'(out_valid), 32'd1);
    set_op(OP_SLL, 32'd0, 32'd1, 5'd31); push(32'h8000_0000, 8'd5);
    @(negedge clk); check("stream_pulse3", 32'(out_valid), 32'd1);
    set_op(OP_SRL, 32'd0, 32'h8000_0000, 5'd31); push(32'h1, 8'd6);
    @(negedge clk); check("stream_pulse4", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    @(negedge clk); check("stream_end", 32'(out_valid), 32'd0);

    // shamt=0 passes b through
    set_op(OP_SLL, 32'd0, 32'h1234_5678, 5'd0); push(32'h1234_5678, 8'd7);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);

    // MUL -1 * -1: busy window N+1..N+32, result at N+33, new op accepted at N+33
    set_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0); push(32'h1, 8'd8);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (k == 1 || k == 32 || k == 33) begin
        check($sformatf("mul1_busy_k%0d", k), 32'(busy), (k <= 32) ? 32'd1 : 32'd0);
        check($sformatf("mul1_out_valid_k%0d", k), 32'(out_valid), (k == 33) ? 32'd1 : 32'd0);
      end
    end
    set_op(OP_ADD, 32'd7, 32'd8, 5'd0); push(32'd15, 8'd9);
    @(negedge clk); in_valid = 1'b0;
    check("post_mul_add_latency", 32'(out_valid), 32'd1);
    @(negedge clk);

    // MUL 12345*6789 with an ADD offered during busy that must be dropped
    set_op(OP_MUL, 32'd12345, 32'd6789, 5'd0); push(32'd83810205, 8'd10);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k >= 5 && k <= 7) set_op(OP_ADD, 32'd100, 32'd1, 5'd0);
      else in_valid = 1'b0;
    end
    check("mul2_done_pulse", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("mul2_no_second_pulse", 32'(out_valid), 32'd0);

    // Reset at cycle N+10 of a MUL aborts it silently
    set_op(OP_MUL, 32'd3, 32'd4, 5'd0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", result, 32'd0);
    repeat (40) @(negedge clk);
    set_op(OP_ADD, 32'd2, 32'd3, 5'd0); push(32'd5, 8'd11);
    @(negedge clk); in_valid = 1'b0;
    check("abort_then_add_latency", 32'(out_valid), 32'd1);
    @(negedge clk);

    // Reset and in_valid together: op dropped
    set_op(OP_ADD, 32'd9, 32'd9, 5'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    check("reset_drops_op", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("reset_drops_op_late", 32'(out_valid), 32'd0);

    // NOP and undefined code still pulse with result 0 / zero 1
    set_op(OP_NOP, 32'hDEAD_BEEF, 32'h1, 5'd3); push(32'd0, 8'd12);
    @(negedge clk);
    set_op(4'b1010, 32'hDEAD_BEEF, 32'h1, 5'd3); push(32'd0, 8'd13);
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage ALU for the pipelined processor, sitting directly downstream of the ALU control decoder. It consumes the 4-bit `operation` code and the ID/EX operands, and produces a registered result plus a zero flag for the EX/MEM register. Single-cycle operations complete in one clock. MULTIPLY runs as a 32-iteration shift-add sequence, and `busy` stalls the front of the pipeline while it runs.

## Interface
- `WIDTH`, 32, operand/result width; the multiply counter is sized to log2(WIDTH)+1 bits.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: operation/operands valid this cycle.
- `operation` in 4: ALU operation code from the control decoder.
- `a` in WIDTH: operand A (rs).
- `b` in WIDTH: operand B (rt or sign-extended immediate).
- `shamt` in 5: shift amount (instr[10:6]).
- `out_valid` out 1: one-cycle pulse, `result`/`zero` valid.
- `result` out WIDTH: registered result, held until next `out_valid`.
- `zero` out 1: registered, 1 when the `result` being delivered is 0.
- `busy` out 1: registered; multiply in progress, upstream must stall.

## Operation
- Codes: 0000 NOP, 0001 ADD, 0010 SUB, 0011 MUL, 0100 AND, 0101 OR, 0110 SRL, 0111 SLL.
- Codes 1000–1111 are treated as NOP.
- ADD/SUB: a+b, a−b mod 2^WIDTH; no overflow flag, no trap.
- AND/OR: bitwise.
- SRL: b >> shamt, zero-fill. SLL: b << shamt.
- NOP: result 0, zero 1, `out_valid` still pulses; this keeps slot timing in the pipeline.
- MUL: low WIDTH bits of a×b, identical for signed and unsigned.
  - Shift-add: accumulator cleared at start; multiplicand shifts left and multiplier shifts right each iteration.
  - Accumulator adds the multiplicand when the multiplier LSB is 1.
- FSM states:
  - IDLE: `in_valid` with MUL → load operands, counter=0 → RUN. Any other `in_valid` → register result, pulse `out_valid`, stay IDLE.
  - RUN: one iteration per cycle, counter++. After iteration WIDTH−1 → DONE.
  - DONE: register accumulator to `result`, pulse `out_valid` → IDLE.
- `in_valid` is ignored whenever state ≠ IDLE. Holding the instruction is upstream's job, driven by `busy`.

## Timing
- Reset values: `out_valid`=0, `result`=0, `zero`=0, `busy`=0, state IDLE, counter 0.
- Single-cycle op accepted at cycle N → `out_valid`=1 with `result` at N+1.
- MUL accepted at N → `busy`=1 on N+1..N+32, `out_valid`=1 at N+33, `busy`=0 at N+33.
- A new op may be accepted at N+33; it is delivered at N+34.
- Back-to-back single-cycle ops: one result per cycle.
- `out_valid` is never high on two consecutive cycles for the same op.
- `reset` mid-multiply: next cycle is IDLE, `busy`=0, no `out_valid` for the aborted op, `result`=0.
- `reset` and `in_valid` in the same cycle: reset wins and the op is dropped.
- `shamt` ≥ 0 always in range 0..31. shamt=0 passes `b` unchanged.

## Structure
- Shared package `alu_pkg` holds:
  - the 4-bit operation code constants (shared with the control decoder);
  - the FSM state encoding (IDLE/RUN/DONE);
  - `WIDTH` default.
- One sub-module, `alu_mul_iter`:
  - holds the accumulator, multiplicand/multiplier shift registers and counter;
  - interface: start, a, b → done, product.
  - The top handles op decode, single-cycle datapath, output registers and `busy`.
- Target: ~200 RTL lines total.

## Test plan
- Reset, then ADD a=0x7FFFFFFF b=1 → N+1: result 0x80000000, zero 0. SUB a=5 b=5 → result 0, zero 1.
- Streaming sequence, one op per cycle: AND 0xF0F0F0F0&0xFF00FF00 → 0xF000F000; OR → 0xFFF0FFF0; SLL b=1 shamt=31 → 0x80000000; SRL b=0x80000000 shamt=31 → 1. Check four consecutive `out_valid` pulses.
- MUL a=0xFFFFFFFF b=0xFFFFFFFF at N:
  - `busy` high exactly N+1..N+32;
  - result 0x00000001 at N+33, single pulse.
- MUL a=12345 b=6789 → 83810205. An ADD is driven with `in_valid` during `busy` and must be ignored (no extra `out_valid`).
- `reset` asserted at cycle N+10 of a MUL → next cycle `busy`=0, no `out_valid` ever for that MUL. A following ADD 2+3 → 5 at one cycle latency.
- NOP (0000) and undefined code 1010 → `out_valid`=1, result 0, zero 1.
